score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 43 ++++
 rtl/score_display_seg7_encode.sv | 26 ++
 rtl/score_display.sv | 127 ++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM states, widths,
// active-low seven-segment patterns and the double-dabble adjust step.
package score_display_pkg;

    localparam int SCORE_W = 24;
    localparam int DIGITS  = 8;
    localparam int CNT_W   = 5;
    localparam int BCD_W   = 4 * DIGITS;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCORE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Add 3 to every nibble >= 5 so the following left shift carries into the next digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/score_display_seg7_encode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal nibbles can never come out of the converter; they show blank.
module seg7_encode
    import score_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Converts a 24-bit binary score to eight BCD digits by serial double-dabble
// and drives eight seven-segment displays, updating them atomically.
module score_display
    import score_display_pkg::*;
#(
    parameter int BLANK_LEADING = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SCORE_W-1:0] score_in,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5,
    output logic [6:0]         hex6,
    output logic [6:0]         hex7,
    output logic [BCD_W-1:0]   bcd_out,
    output logic               busy
);

    localparam logic [6:0] SEG_RST_HI = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_0;

    state_e                   state_q;
    logic [SCORE_W-1:0]       score_q;
    logic [SCORE_W-1:0]       last_val_q;
    logic [SCORE_W-1:0]       bin_q;
    logic [BCD_W-1:0]         bcd_q;
    logic [BCD_W-1:0]         bcd_adj_d;
    logic [BCD_W-1:0]         bcd_out_q;
    logic [CNT_W-1:0]         count_q;
    logic                     busy_q;
    logic [DIGITS-1:0][6:0]   seg_d;
    logic [DIGITS-1:0][6:0]   hex_d;
    logic [DIGITS-1:0][6:0]   hex_q;
    logic [DIGITS-1:1]        lead_zero_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_in;
        end
    end

    assign bcd_adj_d = dabble_adjust(bcd_q);

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        seg7_encode u_seg7_encode (
            .digit_i (bcd_q[4*i +: 4]),
            .seg_o   (seg_d[i])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lead_zero_d = '0;
        hex_d       = seg_d;
        lead_zero_d[DIGITS-1] = (bcd_q[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 1; i--) begin
            lead_zero_d[i] = lead_zero_d[i+1] && (bcd_q[4*i +: 4] == 4'd0);
        end
        for (int i = 1; i < DIGITS; i++) begin
            if ((BLANK_LEADING != 0) && lead_zero_d[i]) begin
                hex_d[i] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_val_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            bcd_out_q  <= '0;
            hex_q      <= {{(DIGITS-1){SEG_RST_HI}}, SEG_0};
        end else begin
            case (state_q)
                IDLE: begin
                    if (score_q != last_val_q) begin
                        bin_q      <= score_q;
                        last_val_q <= score_q;
                        bcd_q      <= '0;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj_d, bin_q} << 1;
                    count_q        <= count_q + CNT_W'(1);
                    if (count_q == LAST_SHIFT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Outputs change only here, so partial accumulators are never visible.
                    bcd_out_q <= bcd_q;
                    hex_q     <= hex_d;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd_out = bcd_out_q;
    assign busy    = busy_q;
    assign hex0    = hex_q[0];
    assign hex1    = hex_q[1];
    assign hex2    = hex_q[2];
    assign hex3    = hex_q[3];
    assign hex4    = hex_q[4];
    assign hex5    = hex_q[5];
    assign hex6    = hex_q[6];
    assign hex7    = hex_q[7];

endmodule
